complex_dot_acc: RTL and testbench

Downstream stage of the complex multiplier (`top_moduletwo`). It takes the stream of complex products (real and imaginary parts, signed Q11.21) and accumulates `N_TERMS` of them into one complex dot-product element of the 32×32 matrix product. The result is presented on a valid/ready output handshake with full bit growth, so no saturation or overflow is possible.

---
 rtl/mat32_pkg.sv | 15 +
 rtl/sext_accum.sv | 44 ++++
 rtl/complex_dot_acc.sv | 116 +++++++++++
 tb/tb_complex_dot_acc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat32_pkg.sv
// Shared definitions for the 32x32 complex matrix-product datapath:
// Q-format widths, dot-product length and the accumulator FSM encoding.
package mat32_pkg;

    localparam int IN_W    = 32;                       // signed Q11.21 product word
    localparam int FRAC_W  = 21;                       // fractional bits, in and out
    localparam int N_TERMS = 32;                       // products per dot-product element
    localparam int ACC_W   = IN_W + $clog2(N_TERMS);   // signed Q16.21, full bit growth

    typedef enum logic {
        ACC  = 1'b0,   // accepting products into the running sum
        HOLD = 1'b1    // completed sum presented, waiting for the consumer
    } acc_state_e;

endpackage

// File: rtl/sext_accum.sv
// One signed accumulator lane: sign-extends each input word to the
// accumulator width and adds it, with a synchronous clear. Used twice,
// once for the real part and once for the imaginary part.
module sext_accum #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 37
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  din_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] din_sext;

    // Binary point stays in place: only the integer part grows.
    assign din_sext = {{(ACC_W-IN_W){din_i[IN_W-1]}}, din_i};

    // Next sum: clear wins over accumulate; otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + din_sext;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/complex_dot_acc.sv
// Complex dot-product accumulator: sums N_TERMS complex products into one
// matrix-product element and hands it downstream with a valid/ready pair.
//
// Handshake rules: an input transfer happens on a rising edge where
// in_valid && in_ready; a result transfer happens where out_valid &&
// out_ready. in_ready and out_valid depend only on the registered state,
// never combinationally on in_valid or out_ready. While out_valid is high
// the result is held stable and all input activity is ignored.
module complex_dot_acc
    import mat32_pkg::*;
#(
    parameter int N_TERMS = mat32_pkg::N_TERMS,
    parameter int IN_W    = mat32_pkg::IN_W,
    parameter int ACC_W   = IN_W + $clog2(N_TERMS)
) (
    input  logic                       clk_acc,
    input  logic                       rst_acc,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_real,
    input  logic [IN_W-1:0]            in_imag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           acc_real,
    output logic [ACC_W-1:0]           acc_imag,
    output logic [$clog2(N_TERMS)-1:0] term_cnt
);

    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    acc_state_e       state_q;
    acc_state_e       state_d;
    logic [CNT_W-1:0] term_cnt_q;
    logic [CNT_W-1:0] term_cnt_d;
    logic             xfer;
    logic             last_term;
    logic             result_taken;

    assign xfer         = in_valid && in_ready;
    assign last_term    = (term_cnt_q == LAST_CNT);
    assign result_taken = (state_q == HOLD) && out_ready;

    // State and term counter registers; reset drops any partial sum.
    always_ff @(posedge clk_acc) begin
        if (rst_acc) begin
            state_q    <= ACC;
            term_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            term_cnt_q <= term_cnt_d;
        end
    end

    // Next state and next count: the final product wraps the count to zero.
    always_comb begin
        state_d    = state_q;
        term_cnt_d = term_cnt_q;
        case (state_q)
            ACC: begin
                if (xfer) begin
                    if (last_term) begin
                        term_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        term_cnt_d = term_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Handshake outputs decoded purely from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC:     in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    assign term_cnt = term_cnt_q;

    sext_accum #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_acc_real (
        .clk_i (clk_acc),
        .rst_i (rst_acc),
        .clr_i (result_taken),
        .en_i  (xfer),
        .din_i (in_real),
        .acc_o (acc_real)
    );

    sext_accum #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_acc_imag (
        .clk_i (clk_acc),
        .rst_i (rst_acc),
        .clr_i (result_taken),
        .en_i  (xfer),
        .din_i (in_imag),
        .acc_o (acc_imag)
    );

endmodule

// File: tb/tb_complex_dot_acc.sv
// Bench for complex_dot_acc: directed vectors, a list-of-products model
// checked every cycle, and literal expectations for each directed case.
module tb_complex_dot_acc;
  import mat32_pkg::*;

  localparam int NT = mat32_pkg::N_TERMS;
  localparam int IW = mat32_pkg::IN_W;
  localparam int AW = mat32_pkg::ACC_W;
  localparam int CW = $clog2(NT);

  // ---------------- clock / reset ----------------
  logic          clk_acc = 1'b0;
  logic          rst_acc = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_real = '0;
  logic [IW-1:0] in_imag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] acc_real;
  logic [AW-1:0] acc_imag;
  logic [CW-1:0] term_cnt;

  always #5 clk_acc = ~clk_acc;

  complex_dot_acc dut (
    .clk_acc   (clk_acc),
    .rst_acc   (rst_acc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_real  (acc_real),
    .acc_imag  (acc_imag),
    .term_cnt  (term_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted products are kept as a list; the sum of the list is the
  // running value, and a full list becomes the held result.
  logic [IW-1:0] m_re[$];
  logic [IW-1:0] m_im[$];
  logic [AW-1:0] exp_q_re[$];
  logic [AW-1:0] exp_q_im[$];
  bit            m_hold = 1'b0;
  bit            started = 1'b0;

  function automatic logic [AW-1:0] list_sum(input logic [IW-1:0] q[$]);
    longint s;
    logic [AW-1:0] r;
    s = 0;
    foreach (q[i]) s += longint'($signed(q[i]));
    r = s[AW-1:0];
    return r;
  endfunction

  always @(posedge clk_acc) begin
    started = 1'b1;
    if (rst_acc) begin
      m_hold = 1'b0;
      m_re.delete();
      m_im.delete();
      exp_q_re.delete();
      exp_q_im.delete();
    end else if (!m_hold) begin
      if (in_valid) begin
        m_re.push_back(in_real);
        m_im.push_back(in_imag);
        if (m_re.size() == NT) begin
          exp_q_re.push_back(list_sum(m_re));
          exp_q_im.push_back(list_sum(m_im));
          m_re.delete();
          m_im.delete();
          m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
      void'(exp_q_re.pop_front());
      void'(exp_q_im.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_acc) begin
    logic [AW-1:0] e_re;
    logic [AW-1:0] e_im;
    logic [CW-1:0] e_cnt;
    if (started) begin
      if (m_hold && exp_q_re.size() > 0) begin
        e_re = exp_q_re[0];
        e_im = exp_q_im[0];
      end else begin
        e_re = list_sum(m_re);
        e_im = list_sum(m_im);
      end
      e_cnt = CW'(m_re.size());
      check("in_ready",  64'(in_ready),  64'(!m_hold));
      check("out_valid", 64'(out_valid), 64'(m_hold));
      check("term_cnt",  64'(term_cnt),  64'(e_cnt));
      check("acc_real",  64'(acc_real),  64'(e_re));
      check("acc_imag",  64'(acc_imag),  64'(e_im));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [IW-1:0] re, input logic [IW-1:0] im, input int gap);
    bit ok;
    int budget;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk_acc); #1;
    end
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    budget   = 0;
    do begin
      @(negedge clk_acc);
      ok = in_ready;
      @(posedge clk_acc); #1;
      budget++;
    end while (!ok && budget < 50);
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk_acc); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_acc = 1'b1;
    @(posedge clk_acc); #1;
    rst_acc = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [AW-1:0] held_re;
  logic [AW-1:0] held_im;

  initial begin
    @(posedge clk_acc); #1;
    @(posedge clk_acc); #1;
    rst_acc = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_term_cnt",  64'(term_cnt),  64'd0);
    check("rst_acc_real",  64'(acc_real),  64'd0);

    // Basic sum: 32 x (1.0, -1.0)
    for (int i = 0; i < NT; i++) begin
      check("basic_pre_valid", 64'(out_valid), 64'd0);
      send(32'h0020_0000, 32'hFFE0_0000, 0);
    end
    check("basic_valid_lat", 64'(out_valid), 64'd1);
    check("basic_real", 64'(acc_real), 64'h00_0400_0000);
    check("basic_imag", 64'(acc_imag), 64'h1F_FC00_0000);
    take_result();
    check("basic_cleared", 64'(acc_real), 64'd0);

    // Negative extreme: 32 x -1024.0 on both parts
    for (int i = 0; i < NT; i++) send(32'h8000_0000, 32'h8000_0000, 0);
    check("neg_real", 64'(acc_real), 64'h10_0000_0000);
    check("neg_imag", 64'(acc_imag), 64'h10_0000_0000);

    // Backpressure with junk on the input
    held_re = acc_real;
    held_im = acc_imag;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_real = $urandom();
      in_imag = $urandom();
      @(negedge clk_acc);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_real_hold", 64'(acc_real),  64'(held_re));
      check("bp_imag_hold", 64'(acc_imag),  64'(held_im));
      @(posedge clk_acc); #1;
    end
    in_valid = 1'b0;
    take_result();
    for (int i = 0; i < NT; i++) send(32'h0020_0000, 32'hFFE0_0000, 0);
    check("after_bp_real", 64'(acc_real), 64'h00_0400_0000);
    check("after_bp_imag", 64'(acc_imag), 64'h1F_FC00_0000);
    take_result();

    // Bubbles: mixed values with random gaps; real sums to 30.0, imag -16.0
    for (int i = 0; i < NT; i++) begin
      logic [IW-1:0] r;
      case (i % 4)
        0:       r = 32'h0010_0000;
        1:       r = 32'hFFF0_0000;
        2:       r = 32'h0068_0000;
        default: r = 32'h0010_0000;
      endcase
      send(r, 32'hFFF0_0000, $urandom_range(0, 3));
    end
    check("bubble_real", 64'(acc_real), 64'h00_03C0_0000);
    check("bubble_imag", 64'(acc_imag), 64'h1F_FE00_0000);
    take_result();

    // Reset mid-sum, then 32 x 2.0
    for (int i = 0; i < 10; i++) send(32'h0020_0000, 32'h0020_0000, 0);
    do_reset();
    check("midrst_cnt", 64'(term_cnt), 64'd0);
    check("midrst_acc", 64'(acc_real), 64'd0);
    for (int i = 0; i < NT; i++) begin
      check("midrst_pre_valid", 64'(out_valid), 64'd0);
      send(32'h0040_0000, 32'h0040_0000, 0);
    end
    check("midrst_real", 64'(acc_real), 64'h00_0800_0000);
    check("midrst_imag", 64'(acc_imag), 64'h00_0800_0000);

    // Reset while holding a result
    check("hold_valid", 64'(out_valid), 64'd1);
    do_reset();
    check("hrst_out_valid", 64'(out_valid), 64'd0);
    check("hrst_in_ready",  64'(in_ready),  64'd1);
    check("hrst_real",      64'(acc_real),  64'd0);
    check("hrst_imag",      64'(acc_imag),  64'd0);

    repeat (3) @(posedge clk_acc);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
